// File: rtl/shrimp_lsu_if.sv
// rtl/shrimp_lsu_if.sv - request, response and memory-file signals of the shrimp load/store unit
interface shrimp_lsu_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_byte;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [15:0]       resp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_write_val;
    logic              mem_write_enable;
    logic [15:0]       mem_read_val;

    // master: the execute stage together with the memory file
    modport master (
        output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
        output resp_ready, mem_read_val,
        input  req_ready, resp_valid, resp_rdata,
        input  mem_addr, mem_write_val, mem_write_enable
    );

    modport slave (
        input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_read_val,
        output req_ready, resp_valid, resp_rdata,
        output mem_addr, mem_write_val, mem_write_enable
    );
endinterface

// File: rtl/shrimp_lsu.sv
// rtl/shrimp_lsu.sv - single-outstanding load/store unit with byte read-modify-write
module shrimp_lsu #(
    parameter int ADDR_W = 8
) (
    input  logic       clock,
    input  logic       reset,
    shrimp_lsu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t            state;
    logic              write_r;
    logic              byte_r;
    logic              signed_r;
    logic [ADDR_W-1:0] addr_r;
    logic [15:0]       wdata_r;
    logic [15:0]       merge_r;
    logic [15:0]       rdata_r;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            write_r  <= 1'b0;
            byte_r   <= 1'b0;
            signed_r <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            merge_r  <= '0;
            rdata_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_r  <= bus.req_write;
                        byte_r   <= bus.req_byte;
                        signed_r <= bus.req_signed;
                        addr_r   <= bus.req_addr;
                        wdata_r  <= bus.req_wdata;
                        state    <= (bus.req_write && !bus.req_byte) ? WRITE : READ;
                    end
                end
                READ: begin
                    if (write_r) begin
                        // byte store: keep the high byte of the current word
                        merge_r <= {bus.mem_read_val[15:8], wdata_r[7:0]};
                        state   <= WRITE;
                    end else begin
                        rdata_r <= byte_r ? {{8{signed_r & bus.mem_read_val[7]}}, bus.mem_read_val[7:0]}
                                          : bus.mem_read_val;
                        state   <= RESP;
                    end
                end
                WRITE: begin
                    rdata_r <= '0;
                    state   <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready        = (state == IDLE);
    assign bus.resp_valid       = (state == RESP);
    assign bus.resp_rdata       = rdata_r;
    assign bus.mem_addr         = addr_r;
    assign bus.mem_write_val    = byte_r ? merge_r : wdata_r;
    // gated by reset so a write caught mid-flight is dropped
    assign bus.mem_write_enable = (state == WRITE) && !reset;
endmodule

// File: tb/tb_shrimp_lsu.sv
// tb/tb_shrimp_lsu.sv - directed self-checking bench for shrimp_lsu with a word-array memory model
module tb_shrimp_lsu;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic load_mem = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   we_cnt = 0;
    int   accepts = 0;
    int   resp_cnt = 0;
    logic [15:0] last_rdata = '0;
    logic [15:0] mem [0:255];

    always #5 clock = ~clock;

    shrimp_lsu_if #(.ADDR_W(8)) bus ();

    shrimp_lsu #(.ADDR_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.mem_read_val = mem[bus.mem_addr];

    always @(posedge clock) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
            mem[8'h20] = 16'h1234;
            mem[8'h30] = 16'h0080;
            mem[8'h32] = 16'h007F;
            mem[8'h40] = 16'h5566;
        end else if (bus.mem_write_enable) begin
            mem[bus.mem_addr] = bus.mem_write_val;
        end
        if (bus.mem_write_enable) we_cnt = we_cnt + 1;
        if (bus.req_valid && bus.req_ready && !reset) accepts = accepts + 1;
        if (bus.resp_valid && bus.resp_ready && !reset) begin
            resp_cnt   = resp_cnt + 1;
            last_rdata = bus.resp_rdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic w, input logic b, input logic s,
                           input logic [7:0] a, input logic [15:0] d);
        bus.req_write  = w;
        bus.req_byte   = b;
        bus.req_signed = s;
        bus.req_addr   = a;
        bus.req_wdata  = d;
    endtask

    // One request, response taken as soon as offered; lat = edges after acceptance until resp_valid
    task automatic run_req(input logic w, input logic b, input logic s,
                           input logic [7:0] a, input logic [15:0] d,
                           output logic [15:0] rd, output int lat);
        @(negedge clock);
        check("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
        set_req(w, b, s, a, d);
        bus.req_valid = 1'b1;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        lat = -1;
        rd  = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            #1;
            if (bus.resp_valid) begin
                lat = k;
                break;
            end
        end
        rd = bus.resp_rdata;
        @(posedge clock);
        #1;
    endtask

    logic [15:0] rd;
    int          lat;
    int          we0;
    int          rc0;

    initial begin
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_rdata", {16'd0, bus.resp_rdata}, 32'd0);
        check("rst_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
        check("rst_mem_wval", {16'd0, bus.mem_write_val}, 32'd0);
        check("rst_mem_we", {31'd0, bus.mem_write_enable}, 32'd0);
        reset    = 1'b0;
        load_mem = 1'b0;

        // word store then load
        we0 = we_cnt;
        run_req(1'b1, 1'b0, 1'b0, 8'h10, 16'hBEEF, rd, lat);
        check("wst_lat", lat, 32'd1);
        check("wst_rdata", {16'd0, rd}, 32'd0);
        check("wst_we_pulses", we_cnt - we0, 32'd1);
        check("wst_mem", {16'd0, mem[8'h10]}, 32'h0000BEEF);
        we0 = we_cnt;
        run_req(1'b0, 1'b0, 1'b0, 8'h10, 16'h0000, rd, lat);
        check("wld_lat", lat, 32'd1);
        check("wld_rdata", {16'd0, rd}, 32'h0000BEEF);
        check("wld_no_we", we_cnt - we0, 32'd0);

        // byte store read-modify-write
        we0 = we_cnt;
        run_req(1'b1, 1'b1, 1'b0, 8'h20, 16'h77AB, rd, lat);
        check("bst_lat", lat, 32'd2);
        check("bst_we_pulses", we_cnt - we0, 32'd1);
        check("bst_mem", {16'd0, mem[8'h20]}, 32'h000012AB);
        run_req(1'b0, 1'b0, 1'b0, 8'h20, 16'h0000, rd, lat);
        check("bst_readback", {16'd0, rd}, 32'h000012AB);

        // byte load extension
        run_req(1'b0, 1'b1, 1'b0, 8'h30, 16'h0000, rd, lat);
        check("bld_u80_lat", lat, 32'd1);
        check("bld_u80", {16'd0, rd}, 32'h00000080);
        run_req(1'b0, 1'b1, 1'b1, 8'h30, 16'h0000, rd, lat);
        check("bld_s80", {16'd0, rd}, 32'h0000FF80);
        run_req(1'b0, 1'b1, 1'b1, 8'h32, 16'h0000, rd, lat);
        check("bld_s7f", {16'd0, rd}, 32'h0000007F);

        // word access at the top address is passed through unchanged
        run_req(1'b1, 1'b0, 1'b0, 8'hFF, 16'hA5C3, rd, lat);
        check("top_addr_mem", {16'd0, mem[8'hFF]}, 32'h0000A5C3);

        // back-pressure
        @(negedge clock);
        bus.resp_ready = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 8'h10, 16'h0000);
        bus.req_valid = 1'b1;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(posedge clock);
        #1;
        check("bp_valid_first", {31'd0, bus.resp_valid}, 32'd1);
        we0 = we_cnt;
        set_req(1'b1, 1'b0, 1'b0, 8'h10, 16'h1111);
        bus.req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            #1;
            check("bp_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
            check("bp_resp_rdata", {16'd0, bus.resp_rdata}, 32'h0000BEEF);
            check("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        check("bp_no_we", we_cnt - we0, 32'd0);
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clock);
        #1;
        check("bp_idle_after", {31'd0, bus.req_ready}, 32'd1);
        check("bp_mem_kept", {16'd0, mem[8'h10]}, 32'h0000BEEF);

        // reset during the write cycle of a byte store
        @(negedge clock);
        we0 = we_cnt;
        set_req(1'b1, 1'b1, 1'b0, 8'h40, 16'h00CC);
        bus.req_valid = 1'b1;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(posedge clock);
        #1;
        check("rmo_we_before", {31'd0, bus.mem_write_enable}, 32'd1);
        check("rmo_wval", {16'd0, bus.mem_write_val}, 32'h000055CC);
        reset = 1'b1;
        #1;
        check("rmo_we_forced0", {31'd0, bus.mem_write_enable}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        check("rmo_mem_unchanged", {16'd0, mem[8'h40]}, 32'h00005566);
        check("rmo_no_we", we_cnt - we0, 32'd0);
        check("rmo_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rmo_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rmo_resp_rdata", {16'd0, bus.resp_rdata}, 32'd0);
        check("rmo_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
        check("rmo_mem_wval", {16'd0, bus.mem_write_val}, 32'd0);

        // back-to-back with req_valid held; fields switch right after each handshake
        @(negedge clock);
        accepts = 0;
        we0 = we_cnt;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] exp_rd;
            case (i)
                0: begin set_req(1'b1, 1'b0, 1'b0, 8'h50, 16'h1111); exp_rd = 16'h0000; end
                1: begin set_req(1'b0, 1'b0, 1'b0, 8'h50, 16'h0000); exp_rd = 16'h1111; end
                2: begin set_req(1'b1, 1'b1, 1'b0, 8'h50, 16'h00AA); exp_rd = 16'h0000; end
                default: begin set_req(1'b0, 1'b0, 1'b0, 8'h50, 16'h0000); exp_rd = 16'h11AA; end
            endcase
            bus.req_valid = 1'b1;
            rc0 = resp_cnt;
            for (int k = 0; k < 20; k++) begin
                @(posedge clock);
                #1;
                if (resp_cnt != rc0) break;
            end
            check("b2b_resp_seen", resp_cnt - rc0, 32'd1);
            check("b2b_rdata", {16'd0, last_rdata}, {16'd0, exp_rd});
        end
        bus.req_valid = 1'b0;
        check("b2b_accepts", accepts, 32'd4);
        check("b2b_we_pulses", we_cnt - we0, 32'd2);
        check("b2b_mem", {16'd0, mem[8'h50]}, 32'h000011AA);

        repeat (2) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shrimp_lsu.md
# shrimp_lsu

Load/store unit for the shrimp CPU: accepts one load or store request at a time from the execute stage and drives the byte-addressed, 16-bit-word data memory file. Word and byte accesses are supported; byte stores are done as a read-modify-write. Responses are returned over a valid/ready handshake. The memory file reads combinationally and writes on the rising clock edge while write-enable is high.

## Interface
- ADDR_W, 8, byte-address width; matches the memory file address port.
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = 16-bit word access.
- req_signed  in  1  byte load only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  16  store data; byte store uses [7:0] only.
- resp_valid  out  1  response available; held until taken.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  16  load result; 0 for stores.
- mem_addr  out  ADDR_W  to memory file address.
- mem_write_val  out  16  to memory file write data.
- mem_write_enable  out  1  to memory file write enable.
- mem_read_val  in  16  from memory file, combinational read of mem_addr.

## Operation
- Word layout is little-endian: byte at address a is word bits [7:0].
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid: latch write, byte, signed, addr, and wdata. Then go to:
  - READ for a load or a byte store;
  - WRITE for a word store.
- READ: drive mem_addr = latched addr and sample mem_read_val at the clock edge.
  - Word load: resp_rdata <= mem_read_val; go to RESP.
  - Byte load: resp_rdata <= {8{signed & val[7]}, val[7:0]}; go to RESP.
  - Byte store: merge register <= {val[15:8], wdata[7:0]}; go to WRITE.
- WRITE: mem_write_enable=1 for exactly this one cycle.
  - mem_write_val = wdata for a word store, or the merge register for a byte store.
  - Clear resp_rdata to 0; go to RESP.
- RESP: resp_valid=1. On resp_ready go to IDLE; otherwise hold RESP with all outputs stable.
- mem_addr always equals the latched address register, including in IDLE (it holds the last request's address).
- mem_write_enable = (state==WRITE) && !reset. It is never high outside WRITE.
- Address arithmetic: none. A word access at 8'hFF is passed to the memory file unchanged; wrap behaviour belongs to the memory.
- Reset (at any state, including WRITE): next state IDLE.
  - In the reset cycle mem_write_enable is forced 0, so a pending write is dropped.
  - All latched registers are cleared to 0.

## Timing
- Reset values: req_ready=1 (state IDLE), resp_valid=0, resp_rdata=0, mem_addr=0, mem_write_val=0, mem_write_enable=0.
- With the request accepted at edge N and resp_ready held high:
  - word load: READ in cycle N..N+1; resp_valid from N+1 to N+2 (latency 2).
  - word store: write commits at edge N+1; resp_valid from N+1 to N+2.
  - byte load: same timing as word load.
  - byte store: read in cycle after N, write commits at edge N+2, resp_valid from N+2 to N+3 (latency 3).
- Throughput: a new request is accepted at the edge on which the response handshake completes plus one cycle (IDLE is visited for one cycle at minimum).
- Requests arriving while not in IDLE are ignored. The requester must hold req_valid.
- Back-pressure: with resp_ready low, RESP persists indefinitely and no memory write occurs.

## Test plan
- Word store then load: store addr 8'h10 data 16'hBEEF, then load 8'h10 -> mem_write_enable pulses once, 1 cycle; load resp_rdata=16'hBEEF at latency 2.
- Byte store RMW: memory[8'h20]=16'h1234; byte store 8'h20 wdata 16'hxxAB -> one read, then write 16'h12AB; word load returns 16'h12AB; store latency 3.
- Byte load extension: word 16'h0080 at 8'h30 -> unsigned byte load=16'h0080, signed=16'hFF80; word 16'h007F signed -> 16'h007F.
- Back-pressure: resp_ready low 5 cycles after a load -> resp_valid and resp_rdata stable, req_ready=0, new req_valid ignored; take response -> IDLE next cycle.
- Reset mid-operation: assert reset in the WRITE cycle of a byte store to 8'h40 -> mem_write_enable=0 that cycle, memory unchanged, all outputs at reset values next cycle.
- Back-to-back requests with req_valid held: 4 alternating loads/stores -> each accepted only in IDLE, no overlapping memory access, data correct.
